// File: rtl/cap_pkg.sv
// Shared types and constants for the image capture/scaler stage.
package cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ACTIVE,
    ST_DONE
  } cap_state_e;

  // Field positions inside the assembled 16-bit RGB565 pixel.
  localparam int R_MSB = 15;
  localparam int G_MSB = 10;
  localparam int B_MSB = 4;

  localparam int H_IN_DEF  = 640;
  localparam int V_IN_DEF  = 480;
  localparam int DECIM_DEF = 2;
  localparam int H_OUT     = H_IN_DEF / DECIM_DEF;
  localparam int V_OUT     = V_IN_DEF / DECIM_DEF;
  localparam int FRAME_PIX = H_OUT * V_OUT;

  function automatic int frame_pix(input int h_in, input int v_in, input int decim);
    return (h_in / decim) * (v_in / decim);
  endfunction

endpackage

// File: rtl/image_capture_scaler_if.sv
// Camera byte bus plus frame-buffer write port of the capture stage.
interface image_capture_scaler_if #(
  parameter int ADDR_W = 17,
  parameter int CH_W   = 4
);
  logic                cap_vsync;
  logic                cap_href;
  logic [7:0]          cap_d;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [3*CH_W-1:0]   dout;

  modport master (output cap_vsync, cap_href, cap_d, input we, addr, dout);
  modport slave  (input cap_vsync, cap_href, cap_d, output we, addr, dout);
endinterface

// File: rtl/cap_rgb_pack.sv
// Pairs camera bytes into RGB565 pixels and truncates each channel to CH_W bits.
module cap_rgb_pack
  import cap_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic              cap_pclk,
  input  logic              cap_rst_n,
  input  logic              cap_vsync,
  input  logic              cap_href,
  input  logic [7:0]        cap_d,
  output logic              odd_phase,
  output logic              pix_valid,
  output logic [3*CH_W-1:0] pix
);

  logic [7:0]  hi_byte;
  logic [15:0] rgb565;
  logic        unused_bits;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge cap_pclk or negedge cap_rst_n) begin
    if (!cap_rst_n) begin
      odd_phase <= 1'b0;
      hi_byte   <= '0;
    end else begin
      if (!cap_href || cap_vsync) odd_phase <= 1'b0;
      else                        odd_phase <= ~odd_phase;
      if (cap_href && !odd_phase) hi_byte <= cap_d;
    end
  end

  // The odd byte completes the pixel in the same cycle it is presented.
  assign rgb565    = {hi_byte, cap_d};
  assign pix_valid = cap_href & odd_phase & ~cap_vsync;
  assign pix       = {rgb565[R_MSB -: CH_W], rgb565[G_MSB -: CH_W], rgb565[B_MSB -: CH_W]};

  // Low-order channel bits are intentionally discarded by the truncation.
  assign unused_bits = ^rgb565;

endmodule

// File: rtl/image_capture_scaler.sv
// Frame-aligned capture FSM, X/Y decimation and linear frame-buffer addressing.
module image_capture_scaler
  import cap_pkg::*;
#(
  parameter int H_IN   = H_IN_DEF,
  parameter int V_IN   = V_IN_DEF,
  parameter int DECIM  = DECIM_DEF,
  parameter int CH_W   = 4,
  parameter int ADDR_W = $clog2(FRAME_PIX)
) (
  input  logic                   cap_pclk,
  input  logic                   cap_rst_n,
  image_capture_scaler_if.slave  bus,
  input  logic                   cap_en,
  input  logic                   cap_single,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt,
  output logic                   line_err,
  output logic                   ovf,
  output logic                   busy
);

  localparam int FRAME_N = frame_pix(H_IN, V_IN, DECIM);
  localparam int X_W     = $clog2(H_IN + 1) + 1;
  localparam int Y_W     = $clog2(V_IN + 1) + 1;

  localparam logic [X_W-1:0]    H_END   = X_W'(H_IN);
  localparam logic [Y_W-1:0]    V_END   = Y_W'(V_IN);
  localparam logic [X_W-1:0]    X_MASK  = X_W'(DECIM - 1);
  localparam logic [Y_W-1:0]    Y_MASK  = Y_W'(DECIM - 1);
  localparam logic [ADDR_W:0]   PTR_END = (ADDR_W + 1)'(FRAME_N);

  cap_state_e        state;
  logic              prev_vsync;
  logic              prev_href;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [Y_W-1:0]    y_inc;
  logic [ADDR_W:0]   wr_ptr;
  logic              odd_phase;
  logic              pix_valid;
  logic [3*CH_W-1:0] pix;
  logic              vs_fall, vs_rise, href_fall, dec_ok;

  cap_rgb_pack #(.CH_W(CH_W)) u_pack (
    .cap_pclk  (cap_pclk),
    .cap_rst_n (cap_rst_n),
    .cap_vsync (bus.cap_vsync),
    .cap_href  (bus.cap_href),
    .cap_d     (bus.cap_d),
    .odd_phase (odd_phase),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  assign vs_fall   = prev_vsync & ~bus.cap_vsync;
  assign vs_rise   = ~prev_vsync & bus.cap_vsync;
  assign href_fall = prev_href & ~bus.cap_href;
  assign dec_ok    = ((x & X_MASK) == '0) && ((y & Y_MASK) == '0);
  // Line accounting is folded in first so a coincident vsync rise sees the new y.
  assign y_inc     = y + Y_W'(href_fall);

  always_ff @(posedge cap_pclk or negedge cap_rst_n) begin
    if (!cap_rst_n) begin
      state      <= ST_IDLE;
      prev_vsync <= 1'b0;
      prev_href  <= 1'b0;
      x          <= '0;
      y          <= '0;
      wr_ptr     <= '0;
      bus.we     <= 1'b0;
      bus.addr   <= '0;
      bus.dout   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      prev_vsync <= bus.cap_vsync;
      prev_href  <= bus.cap_href;
      bus.we     <= 1'b0;
      frame_done <= 1'b0;
      if (bus.cap_vsync) x <= '0;

      case (state)
        ST_IDLE: begin
          if (cap_en) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!cap_en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            state    <= ST_ACTIVE;
            bus.addr <= '0;
            wr_ptr   <= '0;
            x        <= '0;
            y        <= '0;
            line_err <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (pix_valid) begin
            x <= x + 1'b1;
            if (dec_ok) begin
              if (wr_ptr >= PTR_END) begin
                ovf <= 1'b1;
              end else begin
                bus.we   <= 1'b1;
                bus.addr <= wr_ptr[ADDR_W-1:0];
                bus.dout <= pix;
                wr_ptr   <= wr_ptr + 1'b1;
              end
            end
          end
          if (href_fall) begin
            x <= '0;
            y <= y_inc;
            if (odd_phase || x != H_END) line_err <= 1'b1;
          end
          if (vs_rise) begin
            if (y_inc == V_END) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end else begin
              line_err <= 1'b1;
            end
            if (cap_single || !cap_en) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end else begin
              state <= ST_ARMED;
            end
          end
        end
        ST_DONE: begin
          if (!cap_en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_capture_scaler.sv
// Directed bench for image_capture_scaler with an 8x4 frame decimated by 2.
module tb_image_capture_scaler;

  localparam int H_IN = 8, V_IN = 4, DECIM = 2, CH_W = 4, ADDR_W = 4;

  logic       cap_pclk;
  logic       cap_rst_n;
  logic       cap_en, cap_single;
  logic       frame_done, line_err, ovf, busy;
  logic [7:0] frame_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int fd_cnt  = 0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [3*CH_W-1:0] wd_q[$];

  image_capture_scaler_if #(.ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

  image_capture_scaler #(
    .H_IN(H_IN), .V_IN(V_IN), .DECIM(DECIM), .CH_W(CH_W), .ADDR_W(ADDR_W)
  ) dut (
    .cap_pclk   (cap_pclk),
    .cap_rst_n  (cap_rst_n),
    .bus        (bus),
    .cap_en     (cap_en),
    .cap_single (cap_single),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .line_err   (line_err),
    .ovf        (ovf),
    .busy       (busy)
  );

  initial cap_pclk = 1'b0;
  always #5 cap_pclk = ~cap_pclk;

  always @(negedge cap_pclk) begin
    if (bus.we) begin
      wa_q.push_back(bus.addr);
      wd_q.push_back(bus.dout);
    end
    if (frame_done) fd_cnt++;
  end

  function automatic logic [15:0] pix_word(input int ln, input int px);
    return 16'(ln * 'h0841 + px * 'h1111) ^ 16'h5A3C;
  endfunction

  // Expected packed pixel: R[4:1], G[5:2], B[4:1] of the RGB565 word.
  function automatic logic [11:0] exp_pack(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

  task automatic tick();
    @(posedge cap_pclk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    cap_rst_n     = 1'b0;
    cap_en        = 1'b0;
    cap_single    = 1'b0;
    bus.cap_vsync = 1'b0;
    bus.cap_href  = 1'b0;
    bus.cap_d     = 8'h00;
    tick();
    tick();
    cap_rst_n = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.cap_href = 1'b1;
    bus.cap_d    = b;
    tick();
  endtask

  task automatic send_line(input int ln, input int npix);
    logic [15:0] p;
    for (int i = 0; i < npix; i++) begin
      p = pix_word(ln, i);
      send_byte(p[15:8]);
      send_byte(p[7:0]);
    end
    bus.cap_href = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_frame();
    bus.cap_vsync = 1'b1;
    tick();
    tick();
    bus.cap_vsync = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    bus.cap_vsync = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_lines(input int nlines);
    for (int l = 0; l < nlines; l++) send_line(l, H_IN);
  endtask

  task automatic test_reset();
    do_reset();
    cap_en = 1'b1;
    start_frame();
    send_byte(8'hF8);
    send_byte(8'h1F);
    n_total++; if (bus.we !== 1'b1) $display("FAIL reset_pre_we got %b exp 1", bus.we); else n_pass++;
    #2;
    cap_rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.we, bus.addr, bus.dout, frame_done, frame_cnt, line_err, ovf, busy} !== '0)
      $display("FAIL reset_async_zero got we=%b addr=%h dout=%h fd=%b cnt=%0d le=%b ovf=%b busy=%b exp all 0",
               bus.we, bus.addr, bus.dout, frame_done, frame_cnt, line_err, ovf, busy);
    else n_pass++;
    cap_en = 1'b0;
    tick();
    cap_rst_n = 1'b1;
    tick();
    clear_log();
    start_frame();
    run_lines(2);
    end_frame();
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (wa_q.size() != 0) $display("FAIL idle_no_we got %0d writes exp 0", wa_q.size()); else n_pass++;
  endtask

  task automatic test_truncation();
    do_reset();
    cap_en = 1'b1;
    start_frame();
    send_byte(8'hF8);
    n_total++; if (bus.we !== 1'b0) $display("FAIL trunc_we_early got %b exp 0", bus.we); else n_pass++;
    send_byte(8'h1F);
    n_total++; if (bus.we !== 1'b1) $display("FAIL trunc_we got %b exp 1", bus.we); else n_pass++;
    n_total++; if (bus.dout !== 12'hF0F) $display("FAIL trunc_dout_magenta got %h exp f0f", bus.dout); else n_pass++;
    n_total++; if (bus.addr !== 4'd0) $display("FAIL trunc_addr0 got %0d exp 0", bus.addr); else n_pass++;
    send_byte(8'h00);
    send_byte(8'h00);
    n_total++; if (bus.we !== 1'b0) $display("FAIL trunc_decim_skip got %b exp 0", bus.we); else n_pass++;
    send_byte(8'h07);
    send_byte(8'hE0);
    n_total++; if (bus.dout !== 12'h0F0) $display("FAIL trunc_dout_green got %h exp 0f0", bus.dout); else n_pass++;
    n_total++; if (bus.addr !== 4'd1) $display("FAIL trunc_addr1 got %0d exp 1", bus.addr); else n_pass++;
    bus.cap_href = 1'b0;
    tick();
  endtask

  task automatic test_decimation();
    do_reset();
    cap_en = 1'b1;
    start_frame();
    run_lines(V_IN);
    end_frame();
    n_total++; if (wa_q.size() != 8) $display("FAIL decim_count got %0d exp 8", wa_q.size()); else n_pass++;
    for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
      n_total++;
      if (wa_q[k] !== ADDR_W'(k)) $display("FAIL decim_addr%0d got %0d exp %0d", k, wa_q[k], k);
      else n_pass++;
      n_total++;
      if (wd_q[k] !== exp_pack(pix_word((k / 4) * 2, (k % 4) * 2)))
        $display("FAIL decim_dout%0d got %h exp %h", k, wd_q[k], exp_pack(pix_word((k / 4) * 2, (k % 4) * 2)));
      else n_pass++;
    end
    n_total++; if (fd_cnt != 1) $display("FAIL decim_fd got %0d pulses exp 1", fd_cnt); else n_pass++;
    n_total++; if (frame_cnt !== 8'd1) $display("FAIL decim_fcnt got %0d exp 1", frame_cnt); else n_pass++;
    n_total++; if (line_err !== 1'b0) $display("FAIL decim_lerr got %b exp 0", line_err); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL decim_busy got %b exp 1", busy); else n_pass++;
  endtask

  task automatic test_single_shot();
    do_reset();
    cap_en     = 1'b1;
    cap_single = 1'b1;
    start_frame();
    run_lines(V_IN);
    end_frame();
    n_total++; if (wa_q.size() != 8) $display("FAIL single_first got %0d writes exp 8", wa_q.size()); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy got %b exp 0", busy); else n_pass++;
    clear_log();
    for (int f = 0; f < 2; f++) begin
      start_frame();
      run_lines(V_IN);
      end_frame();
    end
    n_total++; if (wa_q.size() != 0) $display("FAIL single_later got %0d writes exp 0", wa_q.size()); else n_pass++;
    n_total++; if (frame_cnt !== 8'd1) $display("FAIL single_fcnt got %0d exp 1", frame_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    cap_en = 1'b1;
    start_frame();
    send_line(0, H_IN - 1);
    n_total++; if (line_err !== 1'b1) $display("FAIL err_short_line got %b exp 1", line_err); else n_pass++;
    for (int l = 1; l < V_IN; l++) send_line(l, H_IN);
    end_frame();
    n_total++; if (line_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", line_err); else n_pass++;
    start_frame();
    n_total++; if (line_err !== 1'b0) $display("FAIL err_cleared got %b exp 0", line_err); else n_pass++;
    clear_log();
    run_lines(V_IN + 1);
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf); else n_pass++;
    n_total++; if (wa_q.size() != 8) $display("FAIL ovf_writes got %0d exp 8", wa_q.size()); else n_pass++;
    n_total++; if (bus.addr !== 4'd7) $display("FAIL ovf_addr_hold got %0d exp 7", bus.addr); else n_pass++;
    end_frame();
  endtask

  task automatic test_abort();
    do_reset();
    cap_en = 1'b1;
    start_frame();
    run_lines(2);
    end_frame();
    n_total++; if (fd_cnt != 0) $display("FAIL abort_fd got %0d pulses exp 0", fd_cnt); else n_pass++;
    n_total++; if (frame_cnt !== 8'd0) $display("FAIL abort_fcnt got %0d exp 0", frame_cnt); else n_pass++;
    n_total++; if (line_err !== 1'b1) $display("FAIL abort_lerr got %b exp 1", line_err); else n_pass++;
    start_frame();
    clear_log();
    send_line(0, H_IN);
    n_total++; if (wa_q.size() != 4) $display("FAIL abort_restart_cnt got %0d exp 4", wa_q.size()); else n_pass++;
    n_total++;
    if (wa_q.size() == 0 || wa_q[0] !== 4'd0) $display("FAIL abort_restart_addr got %0d writes, first addr exp 0", wa_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_truncation();
    test_decimation();
    test_single_shot();
    test_errors();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
